// File: rtl/max_pool_2x2_stream_pkg.sv
// Shared helpers for the pooling variants: width helper, default pixel width
// and a max-of-two that honours signedness.
package max_pool_2x2_stream_pkg;

  localparam int DATAWIDTH_DEFAULT = 16;
  localparam int MAX2_W            = 64;

  // Never returns less than 1, so a depth-1 buffer still gets a 1-bit address.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

  // Operands arrive already sign- or zero-extended to MAX2_W by the caller.
  function automatic logic [MAX2_W-1:0] max2(input logic [MAX2_W-1:0] a,
                                             input logic [MAX2_W-1:0] b,
                                             input logic              is_signed);
    if (is_signed) return ($signed(a) >= $signed(b)) ? a : b;
    return (a >= b) ? a : b;
  endfunction

endpackage

// File: rtl/max_pool_2x2_stream_if.sv
// Pixel stream in, pooled stream out; the upstream conv stage drives the master side.
interface max_pool_2x2_stream_if
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int Datawidth = DATAWIDTH_DEFAULT
);
  logic                 valid_in;
  logic [Datawidth-1:0] In;
  logic [Datawidth-1:0] Out;
  logic                 valid_out;
  logic                 frame_done;

  modport master (output valid_in, In, input Out, valid_out, frame_done);
  modport slave  (input valid_in, In, output Out, valid_out, frame_done);
endinterface

// File: rtl/max_pool_2x2_stream_pool_line_buffer.sv
// Half-width line buffer holding the horizontal maxima of the last even row.
// Simple dual-port RAM with a registered read.
module pool_line_buffer
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = DATAWIDTH_DEFAULT,
  parameter int ADDR_W = clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]  wr_data_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] rd_addr_i,
  output logic [WIDTH-1:0]  rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_addr_i] <= wr_data_i;
    if (rd_en_i) rd_data_q <= mem_q[rd_addr_i];
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/max_pool_2x2_stream.sv
// Streaming 2x2 / stride-2 max pool over a raster-ordered map, no frame buffer.
// Outputs appear one clock after the pixel that completes each window.
module max_pool_2x2_stream
  import max_pool_2x2_stream_pkg::*;
#(
  parameter int IMG_Width  = 8,
  parameter int IMG_Height = 8,
  parameter int Datawidth  = DATAWIDTH_DEFAULT,
  parameter int SIGNED     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  max_pool_2x2_stream_if.slave  pool
);

  localparam int CW       = clog2(IMG_Width);
  localparam int RW       = clog2(IMG_Height);
  localparam int LB_DEPTH = IMG_Width / 2;
  localparam int AW       = clog2(LB_DEPTH);
  localparam logic IS_SIGNED = (SIGNED != 0);

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_Width - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_Height - 1);
  localparam logic [CW-1:0] COL_FD   = CW'(2 * (IMG_Width / 2) - 1);
  localparam logic [RW-1:0] ROW_FD   = RW'(2 * (IMG_Height / 2) - 1);

  logic [CW-1:0]        col_q, col_d;
  logic [RW-1:0]        row_q, row_d;
  logic [Datawidth-1:0] pair_q, pair_d;
  logic [Datawidth-1:0] out_q, out_d;
  logic                 valid_q, valid_d;
  logic                 fd_q, fd_d;

  logic                 accept;
  logic [CW:0]          col_half;
  logic [AW-1:0]        lb_addr;
  logic                 lb_wr_en, lb_rd_en;
  logic [Datawidth-1:0] lb_rd_data;
  logic [MAX2_W-1:0]    h_wide, win_wide;
  logic [Datawidth-1:0] h_max, win_max;

  function automatic logic [MAX2_W-1:0] widen(input logic [Datawidth-1:0] x);
    return {{(MAX2_W - Datawidth){x[Datawidth-1] & IS_SIGNED}}, x};
  endfunction

  assign accept   = pool.valid_in & ~rst;
  assign col_half = {1'b0, col_q} >> 1;
  assign lb_addr  = col_half[AW-1:0];

  assign h_wide   = max2(widen(pair_q), widen(pool.In), IS_SIGNED);
  assign h_max    = h_wide[Datawidth-1:0];
  assign win_wide = max2(widen(lb_rd_data), widen(h_max), IS_SIGNED);
  assign win_max  = win_wide[Datawidth-1:0];

  // Read issued on the even column so the row-above maximum is ready at the odd column.
  pool_line_buffer #(
    .DEPTH (LB_DEPTH),
    .WIDTH (Datawidth),
    .ADDR_W(AW)
  ) u_line_buffer (
    .clk      (clk),
    .wr_en_i  (lb_wr_en),
    .wr_addr_i(lb_addr),
    .wr_data_i(h_max),
    .rd_en_i  (lb_rd_en),
    .rd_addr_i(lb_addr),
    .rd_data_o(lb_rd_data)
  );

  always_comb begin
    col_d    = col_q;
    row_d    = row_q;
    pair_d   = pair_q;
    out_d    = out_q;
    valid_d  = 1'b0;
    fd_d     = 1'b0;
    lb_wr_en = 1'b0;
    lb_rd_en = 1'b0;
    if (accept) begin
      if (col_q == COL_LAST) begin
        col_d = '0;
        row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
      // A trailing odd column/row lands on an even index and so never emits.
      if (!col_q[0]) begin
        pair_d   = pool.In;
        lb_rd_en = row_q[0];
      end else if (!row_q[0]) begin
        lb_wr_en = 1'b1;
      end else begin
        out_d   = win_max;
        valid_d = 1'b1;
        fd_d    = (col_q == COL_FD) && (row_q == ROW_FD);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q   <= '0;
      row_q   <= '0;
      pair_q  <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      pair_q  <= pair_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  assign pool.Out        = out_q;
  assign pool.valid_out  = valid_q;
  assign pool.frame_done = fd_q;

endmodule
